// File: rtl/ifetch_skid_decode.sv
// Two-entry fetch->decode elastic buffer with DLX field decode; 1-cycle latency when empty.
// IN_READY is derived only from the registered count; a pop while full frees the slot for the next cycle.
module ifetch_skid_decode #(
  parameter int PC_W = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INSTR,
  input  logic [PC_W-1:0] IN_PC,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [5:0]      OUT_OPCODE,
  output logic [5:0]      OUT_FUNC,
  output logic [4:0]      OUT_RS1,
  output logic [4:0]      OUT_RS2,
  output logic [4:0]      OUT_RD,
  output logic [15:0]     OUT_IMM,
  output logic            OUT_RTYPE,
  output logic [PC_W-1:0] OUT_PC
);

  logic [31:0]     instr_q [2];
  logic [PC_W-1:0] pc_q    [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  logic push, pop;
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;
  logic            head_rtype;

  assign IN_READY  = (count_q != 2'd2);
  assign OUT_VALID = (count_q != 2'd0);

  assign push = IN_VALID && IN_READY;
  assign pop  = OUT_VALID && OUT_READY;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (FLUSH) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A flushed-cycle word must not land in storage, so writes are gated by FLUSH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
    end else if (push && !FLUSH) begin
      instr_q[wr_ptr_q] <= IN_INSTR;
      pc_q[wr_ptr_q]    <= IN_PC;
    end
  end

  // An empty buffer presents all-zero fields rather than stale storage.
  assign head_instr = OUT_VALID ? instr_q[rd_ptr_q] : 32'd0;
  assign head_pc    = OUT_VALID ? pc_q[rd_ptr_q]    : '0;
  assign head_rtype = OUT_VALID && (head_instr[31:26] == 6'b000000);

  assign OUT_OPCODE = head_instr[31:26];
  assign OUT_RS1    = head_instr[25:21];
  assign OUT_RS2    = head_instr[20:16];
  assign OUT_IMM    = head_instr[15:0];
  assign OUT_FUNC   = head_rtype ? head_instr[5:0]   : 6'd0;
  assign OUT_RD     = head_rtype ? head_instr[15:11] : head_instr[20:16];
  assign OUT_RTYPE  = head_rtype;
  assign OUT_PC     = head_pc;

endmodule

// File: tb/tb_ifetch_skid_decode.sv
// Directed bench for ifetch_skid_decode: decode, back-pressure, streaming, flush, async reset.
module tb_ifetch_skid_decode;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_INSTR;
  logic [31:0] IN_PC;
  logic        FLUSH;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [5:0]  OUT_OPCODE;
  logic [5:0]  OUT_FUNC;
  logic [4:0]  OUT_RS1;
  logic [4:0]  OUT_RS2;
  logic [4:0]  OUT_RD;
  logic [15:0] OUT_IMM;
  logic        OUT_RTYPE;
  logic [31:0] OUT_PC;

  int nvec = 0;
  int nerr = 0;

  ifetch_skid_decode #(.PC_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INSTR(IN_INSTR), .IN_PC(IN_PC),
    .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_OPCODE(OUT_OPCODE), .OUT_FUNC(OUT_FUNC), .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2),
    .OUT_RD(OUT_RD), .OUT_IMM(OUT_IMM), .OUT_RTYPE(OUT_RTYPE), .OUT_PC(OUT_PC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [31:0] itype(input logic [31:0] pc);
    itype = {6'h08, 5'd1, 5'd2, pc[15:0]};
  endfunction

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_INSTR = '0; IN_PC = '0; FLUSH = 1'b0; OUT_READY = 1'b0;
    #2;
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_pc", OUT_PC, 32'd0);
    chk("rst_opcode", 32'(OUT_OPCODE), 32'd0);
    chk("rst_rtype", 32'(OUT_RTYPE), 32'd0);
    tick(); tick();
    RST = 1'b0;

    // R-type single push
    IN_VALID = 1'b1; IN_INSTR = 32'h00A4_1820; IN_PC = 32'h100; OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("r_valid", 32'(OUT_VALID), 32'd1);
    chk("r_opcode", 32'(OUT_OPCODE), 32'd0);
    chk("r_rs1", 32'(OUT_RS1), 32'd5);
    chk("r_rs2", 32'(OUT_RS2), 32'd4);
    chk("r_rd", 32'(OUT_RD), 32'd3);
    chk("r_func", 32'(OUT_FUNC), 32'h20);
    chk("r_imm", 32'(OUT_IMM), 32'h1820);
    chk("r_rtype", 32'(OUT_RTYPE), 32'd1);
    chk("r_pc", OUT_PC, 32'h100);
    tick();
    chk("r_drained", 32'(OUT_VALID), 32'd0);

    // I-type decode
    IN_VALID = 1'b1; IN_INSTR = 32'h8C43_0010; IN_PC = 32'h104;
    tick();
    IN_VALID = 1'b0;
    chk("i_opcode", 32'(OUT_OPCODE), 32'h23);
    chk("i_rs1", 32'(OUT_RS1), 32'd2);
    chk("i_rd", 32'(OUT_RD), 32'd3);
    chk("i_imm", 32'(OUT_IMM), 32'h0010);
    chk("i_func", 32'(OUT_FUNC), 32'd0);
    chk("i_rtype", 32'(OUT_RTYPE), 32'd0);
    tick();
    chk("i_drained", 32'(OUT_VALID), 32'd0);

    // Back-pressure: fill, hold, then drain in order
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_PC = 32'h0; IN_INSTR = itype(32'h0);
    tick();
    chk("bp_ready_after1", 32'(IN_READY), 32'd1);
    IN_PC = 32'h4; IN_INSTR = itype(32'h4);
    tick();
    chk("bp_ready_after2", 32'(IN_READY), 32'd0);
    chk("bp_head0", OUT_PC, 32'h0);
    IN_PC = 32'h8; IN_INSTR = itype(32'h8);
    tick();
    chk("bp_still_full", 32'(IN_READY), 32'd0);
    chk("bp_head_stable", OUT_PC, 32'h0);
    chk("bp_imm_stable", 32'(OUT_IMM), 32'h0);
    OUT_READY = 1'b1;
    tick();
    chk("bp_pop_ready", 32'(IN_READY), 32'd1);
    chk("bp_head4", OUT_PC, 32'h4);
    chk("bp_imm4", 32'(OUT_IMM), 32'h4);
    tick();
    IN_VALID = 1'b0;
    chk("bp_head8", OUT_PC, 32'h8);
    chk("bp_imm8", 32'(OUT_IMM), 32'h8);
    tick();
    chk("bp_empty", 32'(OUT_VALID), 32'd0);

    // Streaming: 16 back-to-back, occupancy stays at 1
    OUT_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1'b1; IN_PC = 32'h200 + 32'(4 * i); IN_INSTR = itype(IN_PC);
      tick();
      chk("st_valid", 32'(OUT_VALID), 32'd1);
      chk("st_pc", OUT_PC, 32'h200 + 32'(4 * i));
      chk("st_ready", 32'(IN_READY), 32'd1);
    end
    IN_VALID = 1'b0;
    tick();
    chk("st_empty", 32'(OUT_VALID), 32'd0);

    // Flush while full, with a word offered in the flush cycle
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    IN_PC = 32'h300; IN_INSTR = itype(IN_PC);
    tick();
    IN_PC = 32'h304; IN_INSTR = itype(IN_PC);
    tick();
    chk("fl_full", 32'(IN_READY), 32'd0);
    FLUSH = 1'b1; IN_PC = 32'h308; IN_INSTR = itype(IN_PC);
    tick();
    chk("fl_valid", 32'(OUT_VALID), 32'd0);
    chk("fl_ready", 32'(IN_READY), 32'd1);
    IN_PC = 32'h30C; IN_INSTR = itype(IN_PC);
    tick();
    chk("fl_empty_offer", 32'(OUT_VALID), 32'd0);
    FLUSH = 1'b0; IN_VALID = 1'b0;
    tick();
    chk("fl_no_ghost", 32'(OUT_VALID), 32'd0);
    IN_VALID = 1'b1; OUT_READY = 1'b1; IN_PC = 32'h310; IN_INSTR = itype(IN_PC);
    tick();
    IN_VALID = 1'b0;
    chk("fl_next_pc", OUT_PC, 32'h310);
    tick();

    // Asynchronous reset between edges while full
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    IN_PC = 32'h400; IN_INSTR = itype(IN_PC);
    tick();
    IN_PC = 32'h404; IN_INSTR = itype(IN_PC);
    tick();
    IN_VALID = 1'b0;
    chk("ar_full", 32'(IN_READY), 32'd0);
    #1 RST = 1'b1;
    #1;
    chk("ar_valid", 32'(OUT_VALID), 32'd0);
    chk("ar_ready", 32'(IN_READY), 32'd1);
    chk("ar_pc", OUT_PC, 32'd0);
    tick();
    RST = 1'b0;
    IN_VALID = 1'b1; OUT_READY = 1'b1; IN_PC = 32'h500; IN_INSTR = itype(IN_PC);
    tick();
    IN_VALID = 1'b0;
    chk("ar_first_push", OUT_PC, 32'h500);
    chk("ar_first_valid", 32'(OUT_VALID), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
